// File: rtl/mux_64b_8to1_reg.sv
// Registered 8:1 word multiplexer for the ALU result-select stage.
// The selected bus, its select code and a valid flag appear one clock after capture.
module mux_64b_8to1_reg #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] F,
    input  logic [WIDTH-1:0] G,
    input  logic [WIDTH-1:0] H,
    input  logic [2:0]       S,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Output,
    output logic             out_valid,
    output logic [2:0]       sel_q
);

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] out_data_d;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_d;
    logic             out_valid_q;
    logic [2:0]       sel_d;

    // Only an unknown select reaches the default; synthesis treats it as don't-care.
    always_comb begin
        sel_data = '0;
        case (S)
            3'b000:  sel_data = A;
            3'b001:  sel_data = B;
            3'b010:  sel_data = C;
            3'b011:  sel_data = D;
            3'b100:  sel_data = E;
            3'b101:  sel_data = F;
            3'b110:  sel_data = G;
            3'b111:  sel_data = H;
            default: sel_data = {WIDTH{1'bx}};
        endcase
    end

    always_comb begin
        out_data_d  = out_data_q;
        sel_d       = sel_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            out_data_d  = sel_data;
            sel_d       = S;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= RESET_VAL;
            out_valid_q <= 1'b0;
            sel_q       <= 3'b000;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sel_q       <= sel_d;
        end
    end

    assign Output    = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_64b_8to1_reg.sv
// Self-checking bench for mux_64b_8to1_reg: directed select scenarios followed by
// randomized traffic, all compared against an array-indexed reference model.
module tb_mux_64b_8to1_reg;

    logic        clk;
    logic        rst;
    logic [63:0] bus [8];
    logic [2:0]  S;
    logic        in_valid;
    logic [63:0] dut_out;
    logic        dut_valid;
    logic [2:0]  dut_sel;

    logic [63:0] exp_out;
    logic        exp_valid;
    logic [2:0]  exp_sel;

    int checks;
    int failures;

    logic [63:0] pattern [8];

    mux_64b_8to1_reg #(
        .WIDTH    (64),
        .RESET_VAL(64'h0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (bus[0]),
        .B        (bus[1]),
        .C        (bus[2]),
        .D        (bus[3]),
        .E        (bus[4]),
        .F        (bus[5]),
        .G        (bus[6]),
        .H        (bus[7]),
        .S        (S),
        .in_valid (in_valid),
        .Output   (dut_out),
        .out_valid(dut_valid),
        .sel_q    (dut_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; case-inequality so X results also count as mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drives one cycle, advances the reference model at the edge, then checks all outputs.
    task automatic applyStimulus(input logic r, input logic v, input logic [2:0] s, input string tag);
        rst      = r;
        in_valid = v;
        S        = s;
        @(posedge clk);
        if (r) begin
            exp_out   = 64'h0;
            exp_valid = 1'b0;
            exp_sel   = 3'b000;
        end else if (v) begin
            exp_out   = bus[s];
            exp_valid = 1'b1;
            exp_sel   = s;
        end else begin
            exp_valid = 1'b0;
        end
        #1;
        checkOutput({tag, ".data"},  dut_out,           exp_out);
        checkOutput({tag, ".valid"}, {63'b0, dut_valid}, {63'b0, exp_valid});
        checkOutput({tag, ".sel"},   {61'b0, dut_sel},   {61'b0, exp_sel});
    endtask

    task automatic loadPattern();
        for (int i = 0; i < 8; i++) bus[i] = pattern[i];
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_out   = 64'h0;
        exp_valid = 1'b0;
        exp_sel   = 3'b000;
        pattern[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        pattern[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        pattern[2] = 64'hCCCC_CCCC_CCCC_CCCC;
        pattern[3] = 64'hDDDD_DDDD_DDDD_DDDD;
        pattern[4] = 64'hEEEE_EEEE_EEEE_EEEE;
        pattern[5] = 64'hFFFF_FFFF_FFFF_FFFF;
        pattern[6] = 64'h1111_1111_1111_1111;
        pattern[7] = 64'h2222_2222_2222_2222;
        loadPattern();
        rst      = 1'b1;
        in_valid = 1'b1;
        S        = 3'b101;

        // Reset wins over an active capture request on both edges.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 3'b101, $sformatf("reset%0d", i));
            checkOutput($sformatf("reset%0d.zero", i), dut_out, 64'h0);
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 3'(i), $sformatf("sweep%0d", i));
            checkOutput($sformatf("sweep%0d.table", i), dut_out, pattern[i]);
        end

        applyStimulus(1'b0, 1'b1, 3'b110, "hold_cap");
        bus[1] = 64'h0;
        applyStimulus(1'b0, 1'b0, 3'b001, "hold");
        checkOutput("hold.const", dut_out, 64'h1111_1111_1111_1111);
        checkOutput("hold.valid0", {63'b0, dut_valid}, 64'h0);
        applyStimulus(1'b0, 1'b0, 3'b001, "hold2");
        loadPattern();

        applyStimulus(1'b0, 1'b1, 3'b011, "track_pre");
        bus[3] = 64'h0123_4567_89AB_CDEF;
        applyStimulus(1'b0, 1'b1, 3'b011, "track");
        checkOutput("track.const", dut_out, 64'h0123_4567_89AB_CDEF);
        loadPattern();

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 3'(i), $sformatf("mid%0d", i));
        applyStimulus(1'b1, 1'b1, 3'b111, "mid_rst");
        checkOutput("mid_rst.zero", dut_out, 64'h0);
        applyStimulus(1'b0, 1'b1, 3'b100, "mid_resume");
        checkOutput("mid_resume.const", dut_out, 64'hEEEE_EEEE_EEEE_EEEE);

        bus[0] = 64'h0000_0000_0000_0001;
        bus[7] = 64'h8000_0000_0000_0000;
        applyStimulus(1'b0, 1'b1, 3'b000, "bit_a");
        checkOutput("bit_a.const", dut_out, 64'h0000_0000_0000_0001);
        applyStimulus(1'b0, 1'b1, 3'b111, "bit_h");
        checkOutput("bit_h.const", dut_out, 64'h8000_0000_0000_0000);

        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 8; i++) bus[i] = {$urandom, $urandom};
            applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                          3'($urandom_range(0, 7)), $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
